// File: rtl/ysyx_24080014_mem_arbiter.sv
// Purpose: shares one memory port between IFU fetches and LSU loads/stores, one transaction in flight.
// Latency: accept -> mem request next cycle -> response forwarded in the same cycle it arrives (2 cycles minimum).
// Backpressure: requesters are held off outside IDLE; mem_resp_ready follows the owner's resp_ready.
// Optional: define ARB_ROUND_ROBIN_EN to alternate grants on a tie (default is fixed LSU priority).
module ysyx_24080014_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    output logic                mem_resp_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                arb_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t stateNext;
    logic   owner;          // 0 = IFU, 1 = LSU
    logic   grantLsu;
    logic   acceptIfu;
    logic   acceptLsu;
    logic   ownerRespRdy;

`ifdef ARB_ROUND_ROBIN_EN
    logic   lastGrant;      // 0 = IFU, 1 = LSU; resets to LSU so IFU wins the first tie
`endif

    // Winner selection among the requests presented while idle
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        if (ifu_req_valid && lsu_req_valid) begin
            grantLsu = ~lastGrant;
        end else begin
            grantLsu = lsu_req_valid;
        end
`else
        grantLsu = lsu_req_valid;
`endif
    end

    // Reset gating keeps ready low while reset is held, so no handshake appears to happen
    assign acceptIfu    = (state == IDLE) && !reset && ifu_req_valid && !grantLsu;
    assign acceptLsu    = (state == IDLE) && !reset && lsu_req_valid && grantLsu;
    assign ownerRespRdy = owner ? lsu_resp_ready : ifu_resp_ready;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state: accept, wait for memory to take the request, wait for the owner to take the response
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (acceptIfu || acceptLsu)             stateNext = REQ;
            REQ:     if (mem_req_ready)                      stateNext = RESP;
            RESP:    if (mem_resp_valid && ownerRespRdy)     stateNext = IDLE;
            default:                                         stateNext = IDLE;
        endcase
    end

    // Owner and request fields captured at accept; IFU requests are always reads with zero write fields
    always_ff @(posedge clock) begin
        if (reset) begin
            owner     <= 1'b0;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            lastGrant <= 1'b1;
`endif
        end else if (acceptLsu) begin
            owner     <= 1'b1;
            mem_addr  <= lsu_addr;
            mem_wen   <= lsu_wen;
            mem_wdata <= lsu_wdata;
            mem_wmask <= lsu_wmask;
`ifdef ARB_ROUND_ROBIN_EN
            lastGrant <= 1'b1;
`endif
        end else if (acceptIfu) begin
            owner     <= 1'b0;
            mem_addr  <= ifu_addr;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            lastGrant <= 1'b0;
`endif
        end
    end

    // Handshake outputs; responses reach only the owner and only in RESP
    always_comb begin
        ifu_req_ready  = acceptIfu;
        lsu_req_ready  = acceptLsu;
        arb_busy       = (state != IDLE);
        mem_req_valid  = 1'b0;
        mem_resp_ready = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        lsu_resp_valid = 1'b0;
        lsu_rdata      = '0;
        case (state)
            REQ: begin
                mem_req_valid = 1'b1;
            end
            RESP: begin
                mem_resp_ready = ownerRespRdy;
                if (owner) begin
                    lsu_resp_valid = mem_resp_valid;
                    lsu_rdata      = mem_rdata;
                end else begin
                    ifu_resp_valid = mem_resp_valid;
                    ifu_rdata      = mem_rdata;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_24080014_mem_arbiter.sv
module tb_ysyx_24080014_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_rdata;
    logic        arb_busy;

    int checks = 0;
    int errors = 0;
    int respCount = 0;

    ysyx_24080014_mem_arbiter dut (
        .clock(clock), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata),
        .arb_busy(arb_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- transaction-level reference model ----------------
    // A transaction is either absent, waiting for memory to accept it, or waiting for its response.
    logic        mBusy, mSent, mOwner, mWen;
    logic [31:0] mAddr, mWdata;
    logic [3:0]  mWmask;
    logic        winLsu;
    logic        eIfuRdy, eLsuRdy, eMemReqV, eRespPhase, eMemRespRdy, eIfuRespV, eLsuRespV;
`ifdef ARB_ROUND_ROBIN_EN
    logic        mLast;   // 1 = LSU was granted last
`endif

    initial begin
        mBusy = 0; mSent = 0; mOwner = 0; mWen = 0;
        mAddr = 0; mWdata = 0; mWmask = 0;
`ifdef ARB_ROUND_ROBIN_EN
        mLast = 1;
`endif
        forever begin
            @(negedge clock);
            if (reset) begin
                mBusy = 0;
                mSent = 0;
`ifdef ARB_ROUND_ROBIN_EN
                mLast = 1;
`endif
            end else begin
                if (ifu_req_valid && lsu_req_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
                    winLsu = !mLast;
`else
                    winLsu = 1'b1;
`endif
                end else begin
                    winLsu = lsu_req_valid;
                end
                eIfuRdy     = !mBusy && ifu_req_valid && !winLsu;
                eLsuRdy     = !mBusy && lsu_req_valid && winLsu;
                eMemReqV    = mBusy && !mSent;
                eRespPhase  = mBusy && mSent;
                eMemRespRdy = eRespPhase && (mOwner ? lsu_resp_ready : ifu_resp_ready);
                eIfuRespV   = eRespPhase && !mOwner && mem_resp_valid;
                eLsuRespV   = eRespPhase && mOwner && mem_resp_valid;

                chk1("m_ifu_req_ready", ifu_req_ready, eIfuRdy);
                chk1("m_lsu_req_ready", lsu_req_ready, eLsuRdy);
                chk1("m_mem_req_valid", mem_req_valid, eMemReqV);
                chk1("m_mem_resp_ready", mem_resp_ready, eMemRespRdy);
                chk1("m_ifu_resp_valid", ifu_resp_valid, eIfuRespV);
                chk1("m_lsu_resp_valid", lsu_resp_valid, eLsuRespV);
                chk1("m_arb_busy", arb_busy, mBusy);
                if (eMemReqV) begin
                    chk32("m_mem_addr", mem_addr, mAddr);
                    chk1("m_mem_wen", mem_wen, mWen);
                    chk32("m_mem_wdata", mem_wdata, mWdata);
                    chk32("m_mem_wmask", {28'd0, mem_wmask}, {28'd0, mWmask});
                end
                if (eIfuRespV) chk32("m_ifu_rdata", ifu_rdata, mem_rdata);
                if (eLsuRespV) chk32("m_lsu_rdata", lsu_rdata, mem_rdata);
                if (eRespPhase && mOwner)  chk32("m_ifu_rdata_nonowner", ifu_rdata, 32'd0);
                if (eRespPhase && !mOwner) chk32("m_lsu_rdata_nonowner", lsu_rdata, 32'd0);

                // advance to the state seen after the coming clock edge
                if (!mBusy) begin
                    if (eLsuRdy) begin
                        mBusy = 1; mSent = 0; mOwner = 1;
                        mAddr = lsu_addr; mWen = lsu_wen; mWdata = lsu_wdata; mWmask = lsu_wmask;
                    end else if (eIfuRdy) begin
                        mBusy = 1; mSent = 0; mOwner = 0;
                        mAddr = ifu_addr; mWen = 0; mWdata = 0; mWmask = 0;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    if (eLsuRdy || eIfuRdy) mLast = eLsuRdy;
`endif
                end else if (!mSent) begin
                    if (mem_req_ready) mSent = 1;
                end else if (mem_resp_valid && eMemRespRdy) begin
                    mBusy = 0;
                    respCount++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic ifuHs, lsuHs, memReqHs, memRespHs, wasReset, memPending, memRespOn;
    logic expLsu;

    task automatic idleInputs();
        ifu_req_valid = 0; ifu_addr = 0; ifu_resp_ready = 0;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0; lsu_resp_ready = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
    endtask

    initial begin
        reset = 1;
        idleInputs();
        repeat (3) @(posedge clock);
        #1 reset = 0;

        // reset state
        @(negedge clock);
        chk1("rst_busy", arb_busy, 1'b0);
        chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk1("rst_mem_resp_ready", mem_resp_ready, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'd0);
        chk32("rst_mem_wdata", mem_wdata, 32'd0);
        chk1("rst_ifu_resp_valid", ifu_resp_valid, 1'b0);
        chk1("rst_lsu_resp_valid", lsu_resp_valid, 1'b0);

        // 1: IFU fetch, memory ready at once
        tick();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1; ifu_resp_ready = 1; lsu_resp_ready = 1;
        @(negedge clock);
        chk1("t1_ifu_req_ready", ifu_req_ready, 1'b1);
        chk1("t1_lsu_req_ready", lsu_req_ready, 1'b0);
        tick();
        ifu_req_valid = 0;
        @(negedge clock);
        chk1("t1_mem_req_valid", mem_req_valid, 1'b1);
        chk32("t1_mem_addr", mem_addr, 32'h8000_0000);
        chk1("t1_mem_wen", mem_wen, 1'b0);
        chk1("t1_ifu_resp_early", ifu_resp_valid, 1'b0);
        tick();
        mem_resp_valid = 1; mem_rdata = 32'h0000_0093;
        @(negedge clock);
        chk1("t1_ifu_resp_valid", ifu_resp_valid, 1'b1);
        chk32("t1_ifu_rdata", ifu_rdata, 32'h0000_0093);
        chk1("t1_lsu_resp_valid", lsu_resp_valid, 1'b0);
        tick();
        mem_resp_valid = 0; mem_rdata = 0; mem_req_ready = 0;
        @(negedge clock);
        chk1("t1_busy_done", arb_busy, 1'b0);

        // 2: LSU store with memory accept delayed 3 cycles
        tick();
        lsu_req_valid = 1; lsu_addr = 32'h8000_0100; lsu_wen = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        @(negedge clock);
        chk1("t2_lsu_req_ready", lsu_req_ready, 1'b1);
        tick();
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        for (int i = 0; i < 4; i++) begin
            mem_req_ready = (i == 3);
            @(negedge clock);
            chk1("t2_mem_req_valid", mem_req_valid, 1'b1);
            chk32("t2_mem_addr", mem_addr, 32'h8000_0100);
            chk32("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk32("t2_mem_wmask", {28'd0, mem_wmask}, 32'h0000_000F);
            chk1("t2_mem_wen", mem_wen, 1'b1);
            tick();
        end
        mem_req_ready = 0; mem_resp_valid = 1;
        @(negedge clock);
        chk1("t2_lsu_ack", lsu_resp_valid, 1'b1);
        chk1("t2_ifu_resp_valid", ifu_resp_valid, 1'b0);
        tick();
        mem_resp_valid = 0;
        @(negedge clock);
        chk1("t2_busy_done", arb_busy, 1'b0);

        // 3: four ties in a row, starting from reset
        tick();
        reset = 1;
        tick();
        reset = 0;
        mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 32'h55;
        ifu_resp_ready = 1; lsu_resp_ready = 1; ifu_addr = 32'h1000; lsu_addr = 32'h2000; lsu_wen = 0;
        for (int k = 0; k < 4; k++) begin
            ifu_req_valid = 1; lsu_req_valid = 1;
`ifdef ARB_ROUND_ROBIN_EN
            expLsu = (k % 2) == 1;
`else
            expLsu = 1'b1;
`endif
            @(negedge clock);
            chk1("t3_lsu_grant", lsu_req_ready, expLsu);
            chk1("t3_ifu_grant", ifu_req_ready, !expLsu);
            tick();
            if (expLsu) lsu_req_valid = 0;
            else        ifu_req_valid = 0;
            tick();
            tick();
        end
        ifu_req_valid = 0; lsu_req_valid = 0; mem_resp_valid = 0; mem_req_ready = 0;
        tick();

        // 4: owner holds off the response for 5 cycles
        ifu_req_valid = 1; ifu_addr = 32'h3000; mem_req_ready = 1; ifu_resp_ready = 0;
        @(negedge clock);
        chk1("t4_accept", ifu_req_ready, 1'b1);
        tick();
        ifu_req_valid = 0;
        tick();
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk1("t4_mem_resp_ready", mem_resp_ready, 1'b0);
            chk1("t4_busy", arb_busy, 1'b1);
            chk1("t4_resp_valid", ifu_resp_valid, 1'b1);
            chk32("t4_rdata", ifu_rdata, 32'h1234_5678);
            tick();
        end
        ifu_resp_ready = 1;
        @(negedge clock);
        chk1("t4_release", mem_resp_ready, 1'b1);
        tick();
        mem_resp_valid = 0;
        @(negedge clock);
        chk1("t4_busy_done", arb_busy, 1'b0);

        // 5: reset in REQ, then in RESP
        tick();
        ifu_req_valid = 1; ifu_addr = 32'h4000;
        tick();
        ifu_req_valid = 0; reset = 1;
        tick();
        reset = 0;
        @(negedge clock);
        chk1("t5a_busy", arb_busy, 1'b0);
        chk1("t5a_mem_req_valid", mem_req_valid, 1'b0);
        chk32("t5a_mem_addr", mem_addr, 32'd0);
        chk1("t5a_ifu_req_ready", ifu_req_ready, 1'b0);
        tick();
        ifu_req_valid = 1; ifu_addr = 32'h5000; mem_req_ready = 1;
        @(negedge clock);
        chk1("t5a_new_accept", ifu_req_ready, 1'b1);
        tick();
        ifu_req_valid = 0;
        tick();
        mem_resp_valid = 1; mem_rdata = 32'hAB; ifu_resp_ready = 0;
        @(negedge clock);
        chk1("t5b_in_resp", ifu_resp_valid, 1'b1);
        tick();
        reset = 1; mem_resp_valid = 0; mem_req_ready = 0;
        tick();
        reset = 0; ifu_resp_ready = 1;
        @(negedge clock);
        chk1("t5b_busy", arb_busy, 1'b0);
        chk1("t5b_mem_resp_ready", mem_resp_ready, 1'b0);
        chk1("t5b_ifu_resp_valid", ifu_resp_valid, 1'b0);
        chk32("t5b_mem_addr", mem_addr, 32'd0);
        tick();
        ifu_req_valid = 1; ifu_addr = 32'h6000; mem_req_ready = 1;
        @(negedge clock);
        chk1("t5b_new_accept", ifu_req_ready, 1'b1);
        tick();
        ifu_req_valid = 0;
        tick();
        mem_resp_valid = 1; mem_rdata = 32'hCD;
        @(negedge clock);
        chk1("t5b_new_resp", ifu_resp_valid, 1'b1);
        tick();
        mem_resp_valid = 0; mem_req_ready = 0;

        // 6: spurious memory response while idle
        mem_resp_valid = 1; mem_rdata = 32'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk1("t6_ifu_resp_valid", ifu_resp_valid, 1'b0);
            chk1("t6_lsu_resp_valid", lsu_resp_valid, 1'b0);
            chk1("t6_busy", arb_busy, 1'b0);
            tick();
        end
        mem_resp_valid = 0;
        tick();

        // random traffic, checked cycle by cycle by the model
        memPending = 0; memRespOn = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            ifuHs     = ifu_req_valid && ifu_req_ready;
            lsuHs     = lsu_req_valid && lsu_req_ready;
            memReqHs  = mem_req_valid && mem_req_ready;
            memRespHs = mem_resp_valid && mem_resp_ready;
            wasReset  = reset;
            tick();
            if (wasReset) begin
                ifu_req_valid = 0; lsu_req_valid = 0; mem_resp_valid = 0;
                memPending = 0; memRespOn = 0;
            end else begin
                if (memRespHs) begin memPending = 0; memRespOn = 0; end
                if (memReqHs)  begin memPending = 1; memRespOn = 0; end
                if (!ifu_req_valid || ifuHs) begin
                    ifu_req_valid = ($urandom_range(0, 2) != 0);
                    ifu_addr      = $urandom;
                end
                if (!lsu_req_valid || lsuHs) begin
                    lsu_req_valid = ($urandom_range(0, 2) != 0);
                    lsu_addr      = $urandom;
                    lsu_wen       = $urandom_range(0, 1) == 1;
                    lsu_wdata     = $urandom;
                    lsu_wmask     = 4'($urandom_range(0, 15));
                end
                if (memPending) begin
                    if (!memRespOn) begin
                        mem_resp_valid = ($urandom_range(0, 2) != 0);
                        mem_rdata      = $urandom;
                        memRespOn      = mem_resp_valid;
                    end
                end else begin
                    mem_resp_valid = ($urandom_range(0, 7) == 0);
                    mem_rdata      = $urandom;
                end
            end
            ifu_resp_ready = ($urandom_range(0, 3) != 0);
            lsu_resp_ready = ($urandom_range(0, 3) != 0);
            mem_req_ready  = ($urandom_range(0, 2) != 0);
            reset          = ($urandom_range(0, 199) == 0);
        end
        reset = 0;
        idleInputs();
        repeat (3) tick();
        chk1("rnd_progress", respCount > 100, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
